// File: rtl/output_cell.sv
// -----------------------------------------------------------------------------
// output_cell
//
// Fabric-to-pad output cell for one IO site. The data path is either a plain
// buffer or a capture register. A registered pad output-enable comes from a
// turnaround state machine. That machine inserts TURN_CYCLES high-Z guard
// cycles before the driver turns on, so a shared pad never sees two drivers
// at once.
//
// Parameters
//   MODE        "out_buff" : OQZ = F2A, combinational
//               "out_reg"  : OQZ is a register loaded from F2A unless held
//   TURN_CYCLES guard cycles between an enable request and driving (0..15)
//   INIT_VALUE  reset value of the data register ("out_reg" only)
//
// Ports
//   IQC   in   clock, rising edge
//   QRT   in   synchronous active-high reset
//   F2A   in   data from fabric toward pad
//   OQE   in   output-enable request (1 = drive pad)
//   OQH   in   hold data register ("out_reg" only)
//   OQZ   out  data to pad driver
//   OEZ   out  pad driver enable (1 = driving), registered
//   OBSY  out  1 while the turnaround guard is counting, registered
// -----------------------------------------------------------------------------
module output_cell #(
    parameter string MODE        = "out_buff",
    parameter int    TURN_CYCLES = 1,
    parameter logic  INIT_VALUE  = 1'b0
) (
    input  logic IQC,
    input  logic QRT,
    input  logic F2A,
    input  logic OQE,
    input  logic OQH,
    output logic OQZ,
    output logic OEZ,
    output logic OBSY
);

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Counter load on entry to TURN. It counts the remaining guard cycles
    // after the entry edge, so TURN lasts exactly TURN_CYCLES edges.
    localparam logic [3:0] TURN_LOAD =
        (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
        $error("output_cell: TURN_CYCLES must be in 0..15");
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // ---------------------------------------------------------------------
    // Enable FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HIZ: begin
                if (OQE) begin
                    if (TURN_CYCLES == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                if (!OQE) begin
                    // Abort. The next request restarts the full guard.
                    state_d = HIZ;
                end else if (cnt_q == 4'd0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRIVE: begin
                if (!OQE) begin
                    state_d = HIZ;
                end
            end
            default: begin
                state_d = HIZ;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Enable FSM: state register and registered outputs
    // OEZ/OBSY are decoded from the next state and then flopped, so OQE has
    // no combinational path to the pad enable.
    // ---------------------------------------------------------------------
    always_ff @(posedge IQC) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, regardless of statement order.
        if (QRT) begin
            state_q <= HIZ;
            cnt_q   <= 4'd0;
            OEZ     <= 1'b0;
            OBSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            OEZ     <= (state_d == DRIVE);
            OBSY    <= (state_d == TURN);
        end
    end

    // ---------------------------------------------------------------------
    // Data path
    // ---------------------------------------------------------------------
    if (MODE == "out_reg") begin : g_reg
        logic data_q;
        always_ff @(posedge IQC) begin
            if (QRT) begin
                data_q <= INIT_VALUE;
            end else if (!OQH) begin
                data_q <= F2A;
            end
        end
        assign OQZ = data_q;
    end else if (MODE == "out_buff") begin : g_buff
        // Hold has no meaning for a pure buffer.
        logic unused_hold;
        assign unused_hold = OQH;
        assign OQZ         = F2A;
    end else begin : g_bad_mode
        $error("output_cell: MODE must be \"out_buff\" or \"out_reg\"");
        logic unused_hold;
        assign unused_hold = OQH;
        assign OQZ         = 1'b0;
    end

endmodule

// File: tb/tb_output_cell.sv
// -----------------------------------------------------------------------------
// tb_output_cell
//
// Four output_cell instances share one set of inputs:
//   u_r3  : out_reg,  TURN_CYCLES=3,  INIT_VALUE=1
//   u_b0  : out_buff, TURN_CYCLES=0
//   u_r2  : out_reg,  TURN_CYCLES=2,  INIT_VALUE=0
//   u_b15 : out_buff, TURN_CYCLES=15
// The reference model tracks how many consecutive edges have sampled OQE high
// since the last drop or reset (run). For guard length N:
//   OEZ  = run >= N+1
//   OBSY = 1 <= run <= N
// -----------------------------------------------------------------------------
module tb_output_cell;

    logic iqc = 1'b0;
    logic qrt, f2a, oqe, oqh;

    logic oqz_r3, oez_r3, obsy_r3;
    logic oqz_b0, oez_b0, obsy_b0;
    logic oqz_r2, oez_r2, obsy_r2;
    logic oqz_b15, oez_b15, obsy_b15;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model state
    int   run   = 0;
    logic qr3_m = 1'b1;
    logic qr2_m = 1'b0;

    always #5 iqc = ~iqc;

    output_cell #(.MODE("out_reg"), .TURN_CYCLES(3), .INIT_VALUE(1'b1)) u_r3 (
        .IQC(iqc), .QRT(qrt), .F2A(f2a), .OQE(oqe), .OQH(oqh),
        .OQZ(oqz_r3), .OEZ(oez_r3), .OBSY(obsy_r3)
    );

    output_cell #(.MODE("out_buff"), .TURN_CYCLES(0), .INIT_VALUE(1'b0)) u_b0 (
        .IQC(iqc), .QRT(qrt), .F2A(f2a), .OQE(oqe), .OQH(oqh),
        .OQZ(oqz_b0), .OEZ(oez_b0), .OBSY(obsy_b0)
    );

    output_cell #(.MODE("out_reg"), .TURN_CYCLES(2), .INIT_VALUE(1'b0)) u_r2 (
        .IQC(iqc), .QRT(qrt), .F2A(f2a), .OQE(oqe), .OQH(oqh),
        .OQZ(oqz_r2), .OEZ(oez_r2), .OBSY(obsy_r2)
    );

    output_cell #(.MODE("out_buff"), .TURN_CYCLES(15), .INIT_VALUE(1'b0)) u_b15 (
        .IQC(iqc), .QRT(qrt), .F2A(f2a), .OQE(oqe), .OQH(oqh),
        .OQZ(oqz_b15), .OEZ(oez_b15), .OBSY(obsy_b15)
    );

    task automatic check(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic exp_oez(input int n);
        return (run >= n + 1);
    endfunction

    function automatic logic exp_obsy(input int n);
        return (run >= 1 && run <= n);
    endfunction

    // One clock cycle: drive inputs at the falling edge, check the buffered
    // data path combinationally, then update the model on the rising edge
    // and check every registered output 1 time unit later.
    task automatic step(input logic rst, input logic en, input logic d, input logic hold);
        @(negedge iqc);
        qrt = rst;
        oqe = en;
        f2a = d;
        oqh = hold;
        #1;
        check("b0_oqz_comb", oqz_b0, d);
        check("b15_oqz_comb", oqz_b15, d);

        @(posedge iqc);
        cyc++;
        if (rst) begin
            run   = 0;
            qr3_m = 1'b1;
            qr2_m = 1'b0;
        end else begin
            run = en ? ((run < 100) ? run + 1 : run) : 0;
            if (!hold) begin
                qr3_m = d;
                qr2_m = d;
            end
        end
        #1;
        check("r3_oqz",   oqz_r3,   qr3_m);
        check("r2_oqz",   oqz_r2,   qr2_m);
        check("r3_oez",   oez_r3,   exp_oez(3));
        check("r3_obsy",  obsy_r3,  exp_obsy(3));
        check("b0_oez",   oez_b0,   exp_oez(0));
        check("b0_obsy",  obsy_b0,  exp_obsy(0));
        check("r2_oez",   oez_r2,   exp_oez(2));
        check("r2_obsy",  obsy_r2,  exp_obsy(2));
        check("b15_oez",  oez_b15,  exp_oez(15));
        check("b15_obsy", obsy_b15, exp_obsy(15));
    endtask

    initial begin
        logic [3:0] data_seq;
        logic [3:0] hold_seq;
        logic       en;

        qrt = 1'b1;
        oqe = 1'b0;
        f2a = 1'b0;
        oqh = 1'b0;

        // Reset with enable requested and F2A low: the register shows
        // INIT_VALUE and the enable stays off. The first free edge loads F2A.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Long request: covers the guard of every instance, including 15.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, i[0], 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle glitch, then a re-raise two cycles later.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Data path with hold: F2A=1,0,1,1 and OQH=0,0,1,0 give 1,0,0,1.
        // The bit strings are read LSB first.
        data_seq = 4'b1101;
        hold_seq = 4'b0100;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, data_seq[i], hold_seq[i]);

        // Reset while driving with the request still high: the guard restarts.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic. Enable changes rarely so long runs occur, and
        // occasional resets land mid-sequence.
        en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) en = ~en;
            step(($urandom_range(49) == 0), en, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/output_cell.md
Name: output_cell

Overview:
- Fabric-to-pad output cell; the transmit-direction counterpart of the pad-to-fabric input cell.
- Drives pad data either combinationally or through a capture register.
- Generates a registered pad output-enable through a turnaround state machine. The machine inserts a configurable number of high-Z cycles before the driver turns on, so that a shared pad never sees bus contention.
- Instantiated per IO site alongside the input cell and sharing its clock/reset nets.

Parameters:
- MODE, "out_buff", data path select: "out_buff" = combinational, "out_reg" = registered.
- TURN_CYCLES, 1, number of high-Z guard cycles (0..15) inserted between an output-enable request and the driver turning on.
- INIT_VALUE, 1'b0, value loaded into the data register by reset ("out_reg" only).

Ports:
- IQC  input  1  clock; all state updates on the rising edge.
- QRT  input  1  reset; synchronous, active-high.
- F2A  input  1  data from fabric toward pad.
- OQE  input  1  output-enable request from fabric (1 = drive pad).
- OQH  input  1  hold; when 1, the data register keeps its value ("out_reg" only).
- OQZ  output 1  data to pad driver.
- OEZ  output 1  pad driver enable (1 = driving, 0 = high-Z); registered.
- OBSY output 1  1 while the turnaround guard is counting.

Behaviour:
- Reset (QRT=1 at a rising IQC edge):
  - state=HIZ, counter=0, OEZ=0, OBSY=0.
  - "out_reg": data register = INIT_VALUE.
  - Reset has priority over every other input in the same cycle, including mid-turnaround and during DRIVE.
- Data path, "out_buff": OQZ = F2A combinationally, zero latency; OQH is ignored.
- Data path, "out_reg":
  - OQZ is the data register output.
  - Each edge with QRT=0 and OQH=0 loads F2A, giving 1-cycle latency.
  - When OQH=1 the register holds its value.
- Data path, any other MODE value: elaboration error.
- Enable FSM runs identically in both modes and is unaffected by OQH. Its 4-bit down-counter is only meaningful in TURN.
- HIZ state:
  - OQE=1 and TURN_CYCLES=0 -> DRIVE.
  - OQE=1 and TURN_CYCLES>0 -> TURN, counter=TURN_CYCLES-1.
  - Otherwise stay in HIZ.
- TURN state:
  - OQE=0 -> HIZ (abort; the counter value is don't-care).
  - Else counter==0 -> DRIVE.
  - Else counter decrements.
- DRIVE state:
  - OQE=0 -> HIZ.
  - Otherwise stay in DRIVE.
- Outputs are registered from next-state: OEZ=1 iff state==DRIVE, OBSY=1 iff state==TURN. There are no combinational paths from OQE to OEZ/OBSY.
- Latency:
  - Driver on: OQE rising before edge k gives OEZ=1 after edge k+TURN_CYCLES, i.e. TURN_CYCLES+1 edges, provided OQE stays high.
  - Driver off: OQE falling before edge k gives OEZ=0 after edge k (1 edge), from DRIVE or TURN.
- OQE glitch: a 1-cycle OQE pulse with TURN_CYCLES>=1 never asserts OEZ. The FSM returns to HIZ and the next request restarts the full guard count.
- OQZ is valid regardless of OEZ; the pad ignores it when OEZ=0.
- TURN_CYCLES outside 0..15: elaboration error.

Test Plan:
- Reset: MODE="out_reg", INIT_VALUE=1, hold QRT=1 for 2 edges with OQE=1, F2A=0 -> OQZ=1, OEZ=0, OBSY=0 throughout reset; the first edge after release loads OQZ=0.
- Turnaround: TURN_CYCLES=3, raise OQE and keep it high -> OBSY=1 after edges 1..3, OEZ=1 from edge 4 onward. Drop OQE -> OEZ=0 one edge later.
- Zero guard: TURN_CYCLES=0, raise OQE -> OEZ=1 after the first edge, OBSY never 1.
- Abort: TURN_CYCLES=2, pulse OQE for one cycle, then raise it again 2 cycles later -> OEZ stays 0 during the pulse; after the re-raise OBSY=1 for 2 edges, then OEZ=1 on the 3rd edge.
- Data path:
  - "out_reg": drive F2A=1,0,1,1 with OQH=0,0,1,0 -> OQZ after each edge = 1,0,0,1.
  - "out_buff": same stimulus -> OQZ tracks F2A in the same cycle.
- Reset mid-operation: in DRIVE, assert QRT for one edge with OQE=1 still high -> OEZ=0 after that edge, then OBSY=1 after the next edge (full TURN_CYCLES guard restarts), then OEZ returns to 1.
